// File: rtl/sap2_ctrl.sv
`timescale 1ns/1ps
// Hardwired control sequencer for SAP-2-mini: six-state one-hot ring plus opcode/flag decode to a 30-bit control word.
// Latency: con is combinational from state, i and flags; hlt is registered, set by the edge leaving T3 of HLT.
// Backpressure: none; the ring advances every edge unless halted or in the first edge after reset release.
module sap2_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic        am,
  input  logic        az,
  input  logic        xm,
  input  logic        xz,
  input  logic [7:0]  i,
  output logic [29:0] con,
  output logic        hlt
);

  localparam logic [5:0] T1 = 6'b000001;

  // control word bit positions
  localparam int B_CP = 29, B_EP = 28, B_LP = 27, B_LM = 26, B_ER = 25, B_WR = 24;
  localparam int B_LI = 23, B_EI = 22, B_LA = 21, B_EA = 20, B_LB = 19, B_EB = 18;
  localparam int B_LX = 17, B_EX = 16, B_IX = 15, B_DX = 14, B_EU = 13;
  localparam int B_LT = 8,  B_ET = 7,  B_LO = 6,  B_EN = 5,  B_CA = 4;

  logic [5:0]  sc_q, sc_d;
  logic        run_q;
  logic        hlt_q, hlt_d;
  logic [29:0] con_d;
  logic [3:0]  op;
  logic [3:0]  sub;
  logic        jmp_take;

  assign op  = i[7:4];
  assign sub = i[3:0];

  // State register: ring position, post-reset hold flag and sticky halt
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sc_q  <= T1;
      run_q <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      run_q <= 1'b1;
      hlt_q <= hlt_d;
    end
  end

  // Next state: rotate the ring unless holding after reset or halted; HLT latches at the end of T3
  always_comb begin
    sc_d  = sc_q;
    hlt_d = hlt_q;
    if (run_q && !hlt_q) begin
      sc_d = {sc_q[4:0], sc_q[5]};
      if (sc_q[2] && (i == 8'hFF)) hlt_d = 1'b1;
    end
  end

  // Output decode: fetch in T1/T2, opcode-specific execute steps in T3..T6
  always_comb begin
    con_d    = '0;
    jmp_take = 1'b0;
    case (op)
      4'h6:    jmp_take = 1'b1;
      4'h7:    jmp_take = am;
      4'h8:    jmp_take = az;
      4'h9:    jmp_take = xm;
      4'hA:    jmp_take = xz;
      default: jmp_take = 1'b0;
    endcase
    if (clr && !hlt_q) begin
      if (sc_q[0]) begin
        con_d[B_EP] = 1'b1; con_d[B_LM] = 1'b1;
      end else if (sc_q[1]) begin
        con_d[B_CP] = 1'b1; con_d[B_ER] = 1'b1; con_d[B_LI] = 1'b1;
      end else begin
        case (op)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            if (sc_q[2]) begin
              con_d[B_EI] = 1'b1; con_d[B_LM] = 1'b1;
            end
            if (sc_q[3]) begin
              con_d[B_ER] = (op != 4'h3);
              con_d[B_EA] = (op == 4'h3);
              con_d[B_WR] = (op == 4'h3);
              con_d[B_LA] = (op == 4'h0);
              con_d[B_LB] = (op == 4'h1) || (op == 4'h2) || (op == 4'h4);
              con_d[B_LX] = (op == 4'h5);
            end
            if (sc_q[4] && (op == 4'h1 || op == 4'h2)) begin
              con_d[B_EU] = 1'b1; con_d[B_LA] = 1'b1;
              con_d[12:9] = (op == 4'h2) ? 4'd1 : 4'd0;
            end
          end
          4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
            if (sc_q[2] && jmp_take) begin
              con_d[B_EI] = 1'b1; con_d[B_LP] = 1'b1;
            end
          end
          4'hB: begin
            if (sc_q[2]) begin con_d[B_EI] = 1'b1; con_d[B_LM] = 1'b1; end
            if (sc_q[3]) begin con_d[B_EP] = 1'b1; con_d[B_WR] = 1'b1; end
            if (sc_q[4]) begin con_d[B_EI] = 1'b1; con_d[B_LP] = 1'b1; end
            if (sc_q[5]) con_d[B_CP] = 1'b1;
          end
          4'hF: begin
            if (sc_q[2]) begin
              case (sub)
                4'h1: con_d[B_CA] = 1'b1;
                4'h2: begin con_d[B_EA] = 1'b1; con_d[B_LT] = 1'b1; end
                4'h3: con_d[B_DX] = 1'b1;
                4'h4: con_d[B_IX] = 1'b1;
                // ALU sub-opcodes 5..B map onto ALU ops 2..8
                4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
                  con_d[B_EU] = 1'b1;
                  con_d[12:9] = sub - 4'd3;
                  con_d[B_LB] = (sub == 4'h6);
                  con_d[B_LA] = (sub != 4'h6);
                end
                4'hC: begin con_d[B_EB] = 1'b1; con_d[B_LA] = 1'b1; end
                4'hD: begin con_d[B_EN] = 1'b1; con_d[B_LA] = 1'b1; end
                4'hE: begin con_d[B_EA] = 1'b1; con_d[B_LO] = 1'b1; end
                default: con_d = '0;
              endcase
            end
            if (sc_q[3] && sub == 4'h2) begin con_d[B_EX] = 1'b1; con_d[B_LA] = 1'b1; end
            if (sc_q[4] && sub == 4'h2) begin con_d[B_ET] = 1'b1; con_d[B_LX] = 1'b1; end
          end
          default: con_d = '0;
        endcase
      end
    end
  end

  assign con = con_d;
  assign hlt = hlt_q;

endmodule

// File: tb/tb_sap2_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sap2_ctrl: reference model tracks T-state/halt as integers and
// looks up the control word from a table of literal words per instruction and step.
module tb_sap2_ctrl;

  logic        clk;
  logic        clr;
  logic        am, az, xm, xz;
  logic [7:0]  i;
  logic [29:0] con;
  logic        hlt;

  int n_vec;
  int n_err;

  // reference model state
  int m_t;
  bit m_hlt;
  bit m_hold;

  sap2_ctrl dut (
    .clk (clk),
    .clr (clr),
    .am  (am),
    .az  (az),
    .xm  (xm),
    .xz  (xz),
    .i   (i),
    .con (con),
    .hlt (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t, model T%0d)", name, act, exp, $time, m_t);
    end
  endtask

  function automatic logic [29:0] model_con();
    logic [3:0] op;
    logic [3:0] s;
    logic [29:0] r;
    bit take;
    op = i[7:4];
    s  = i[3:0];
    r  = 30'h0;
    if (!clr || m_hlt) return 30'h0;
    if (m_t == 1) return 30'h14000000;
    if (m_t == 2) return 30'h22800000;
    take = (op == 4'h6) || (op == 4'h7 && am) || (op == 4'h8 && az) ||
           (op == 4'h9 && xm) || (op == 4'hA && xz);
    case (op)
      4'h0: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h02200000 : 30'h0;
      4'h1: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h02080000 : (m_t == 5) ? 30'h00202000 : 30'h0;
      4'h2: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h02080000 : (m_t == 5) ? 30'h00202200 : 30'h0;
      4'h3: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h01100000 : 30'h0;
      4'h4: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h02080000 : 30'h0;
      4'h5: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h02020000 : 30'h0;
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA: r = (m_t == 3 && take) ? 30'h08400000 : 30'h0;
      4'hB: r = (m_t == 3) ? 30'h04400000 : (m_t == 4) ? 30'h11000000 :
                (m_t == 5) ? 30'h08400000 : 30'h20000000;
      4'hF: begin
        if (m_t == 3) begin
          case (s)
            4'h1: r = 30'h00000010;
            4'h2: r = 30'h00100100;
            4'h3: r = 30'h00004000;
            4'h4: r = 30'h00008000;
            4'h5: r = 30'h00202400;
            4'h6: r = 30'h00082600;
            4'h7: r = 30'h00202800;
            4'h8: r = 30'h00202A00;
            4'h9: r = 30'h00202C00;
            4'hA: r = 30'h00202E00;
            4'hB: r = 30'h00203000;
            4'hC: r = 30'h00240000;
            4'hD: r = 30'h00200020;
            4'hE: r = 30'h00100040;
            default: r = 30'h0;
          endcase
        end else if (s == 4'h2) begin
          r = (m_t == 4) ? 30'h00210000 : (m_t == 5) ? 30'h00020080 : 30'h0;
        end
      end
      default: r = 30'h0;
    endcase
    return r;
  endfunction

  // model reaction to a rising clock edge (reads inputs as they stand at the edge)
  task automatic model_edge();
    if (!clr || m_hlt) return;
    if (m_hold) begin
      m_hold = 1'b0;
      return;
    end
    if (m_t == 3 && i == 8'hFF) m_hlt = 1'b1;
    m_t = (m_t == 6) ? 1 : m_t + 1;
  endtask

  // one clock: edge, new inputs, optional mid-cycle flag change, compare at falling edge
  task automatic step(input logic [7:0] ni, input logic [3:0] nf, input bit glitch);
    @(posedge clk);
    model_edge();
    #2;
    i = ni;
    {am, az, xm, xz} = nf;
    if (glitch && $urandom_range(0, 2) == 0) begin
      #1;
      {am, az, xm, xz} = 4'($urandom);
    end
    @(negedge clk);
    chk("con", {2'b00, con}, {2'b00, model_con()});
    chk("hlt", {31'h0, hlt}, {31'h0, m_hlt});
  endtask

  // asynchronous reset pulse starting between edges, released after one rising edge
  task automatic pulse_reset();
    #1;
    clr    = 1'b0;
    m_t    = 1;
    m_hlt  = 1'b0;
    m_hold = 1'b1;
    #1;
    chk("rst_con", {2'b00, con}, 32'h0);
    chk("rst_hlt", {31'h0, hlt}, 32'h0);
    @(posedge clk);
    #3;
    clr = 1'b1;
  endtask

  // six cycles with fixed inputs; pin the word at one T-state with a literal
  task automatic run_instr(input logic [7:0] ni, input logic [3:0] nf, input int lit_t,
                           input logic [29:0] lit, input string name);
    for (int k = 0; k < 6; k++) begin
      step(ni, nf, 1'b0);
      if (m_t == lit_t) chk(name, {2'b00, con}, {2'b00, lit});
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    clr    = 1'b0;
    i      = 8'h0F;
    {am, az, xm, xz} = 4'b0000;
    m_t    = 1;
    m_hlt  = 1'b0;
    m_hold = 1'b1;

    // reset state
    #3;
    chk("init_con", {2'b00, con}, 32'h0);
    chk("init_hlt", {31'h0, hlt}, 32'h0);
    @(posedge clk);
    #3;
    clr = 1'b1;

    // LDA 15 free-run: hold cycle in T1, then T2..T6, then T1 on the 7th
    begin
      logic [29:0] lda_exp [7];
      lda_exp = '{30'h14000000, 30'h22800000, 30'h04400000, 30'h02200000,
                  30'h0, 30'h0, 30'h14000000};
      for (int k = 0; k < 7; k++) begin
        step(8'h0F, 4'b0000, 1'b0);
        chk("lda_seq", {2'b00, con}, {2'b00, lda_exp[k]});
      end
    end

    run_instr(8'h13, 4'b0000, 5, 30'h00202000, "add_t5");
    run_instr(8'h23, 4'b0000, 5, 30'h00202200, "sub_t5");

    // conditional jumps: other flags set to show the right one is selected
    run_instr(8'h75, 4'b0111, 3, 30'h0,        "jan_nt");
    run_instr(8'h75, 4'b1000, 3, 30'h08400000, "jan_t");
    run_instr(8'h85, 4'b1011, 3, 30'h0,        "jaz_nt");
    run_instr(8'h85, 4'b0100, 3, 30'h08400000, "jaz_t");
    run_instr(8'h95, 4'b1101, 3, 30'h0,        "jin_nt");
    run_instr(8'h95, 4'b0010, 3, 30'h08400000, "jin_t");
    run_instr(8'hA5, 4'b1110, 3, 30'h0,        "jiz_nt");
    run_instr(8'hA5, 4'b0001, 3, 30'h08400000, "jiz_t");

    run_instr(8'hFE, 4'b0000, 3, 30'h00100040, "out_t3");
    run_instr(8'hF2, 4'b0000, 3, 30'h00100100, "xch_t3");
    run_instr(8'hF2, 4'b0000, 4, 30'h00210000, "xch_t4");
    run_instr(8'hF2, 4'b0000, 5, 30'h00020080, "xch_t5");

    // HLT: run until halt, then stay frozen with random inputs
    for (int k = 0; k < 12 && !m_hlt; k++) step(8'hFF, 4'b0000, 1'b0);
    chk("hlt_set", {31'h0, hlt}, 32'h1);
    chk("hlt_state", m_t, 4);
    for (int k = 0; k < 12; k++) step(8'($urandom), 4'($urandom), 1'b1);
    chk("hlt_con", {2'b00, con}, 32'h0);
    chk("hlt_hold", {31'h0, hlt}, 32'h1);
    pulse_reset();
    step(8'h0F, 4'b0000, 1'b0);
    chk("after_hlt_t1", {2'b00, con}, 32'h14000000);

    // JMS interrupted by reset in T4
    for (int k = 0; k < 12 && !(m_t == 4 && !m_hold); k++) step(8'hB3, 4'b0000, 1'b0);
    chk("jms_t4", {2'b00, con}, 32'h11000000);
    pulse_reset();
    step(8'hB3, 4'b0000, 1'b0);
    chk("jms_rst_t1", {2'b00, con}, 32'h14000000);

    // randomized run with occasional resets
    begin
      logic [7:0] ri;
      int halted_cycles;
      ri = 8'h00;
      halted_cycles = 0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 24) == 0) ri = 8'hFF;
          else ri = 8'($urandom);
        end
        step(ri, 4'($urandom), 1'b1);
        if (m_hlt) halted_cycles++;
        if (halted_cycles > 6 || $urandom_range(0, 60) == 0) begin
          halted_cycles = 0;
          pulse_reset();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sap2_ctrl.md
# sap2_ctrl

Hardwired control sequencer for the SAP-2-mini 8-bit CPU. It steps a one-hot ring counter through six T-states per instruction and decodes the instruction register plus four datapath flags into a 30-bit control word that drives the bus, registers, RAM, ALU and I/O. It also raises a sticky halt flag.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `am`  in  1  accumulator negative flag.
- `az`  in  1  accumulator zero flag.
- `xm`  in  1  index register X negative flag.
- `xz`  in  1  X zero flag.
- `i`  in  8  instruction register contents; `i[7:4]` is the opcode, `i[3:0]` is the operand address or sub-opcode.
- `con`  out  30  control word; combinational from the current state, `i` and the flags.
- `hlt`  out  1  halted flag, registered.

Control word bits:
- 29 Cp: increment PC.
- 28 Ep: PC to bus.
- 27 Lp: load PC.
- 26 Lm: load MAR.
- 25 Er: RAM to bus.
- 24 Wr: write RAM.
- 23 Li: load IR.
- 22 Ei: `i[3:0]` to bus.
- 21 La: load A. 20 Ea: A to bus.
- 19 Lb: load B. 18 Eb: B to bus.
- 17 Lx: load X. 16 Ex: X to bus.
- 15 Ix: increment X. 14 Dx: decrement X.
- 13 Eu: ALU to bus.
- 12:9 Op: ALU operation.
- 8 Lt: load temp. 7 Et: temp to bus.
- 6 Lo: load output port.
- 5 En: input port to bus.
- 4 Ca: clear A.
- 3:0 reserved, always 0.

ALU Op codes: 0 A+B, 1 A−B, 2 ~A, 3 ~B, 4 A|B, 5 A&B, 6 ~(A|B), 7 ~(A&B), 8 A^B. Op is 0 whenever Eu=0.

## Operation
- State `sc` is a 6-bit one-hot counter T1..T6. It advances every rising edge and wraps T6→T1.
- Every state emits the bits listed for it. All bits not listed are 0.
- Fetch, identical for all instructions:
  - T1: Ep, Lm.
  - T2: Cp, Er, Li.
- Execute, T3 onward. Steps not listed are idle (con=0).
- LDA (0): T3 Ei,Lm; T4 Er,La.
- ADD (1): T3 Ei,Lm; T4 Er,Lb; T5 Eu,Op=0,La.
- SUB (2): as ADD, with Op=1 at T5.
- STA (3): T3 Ei,Lm; T4 Ea,Wr.
- LDB (4): T3 Ei,Lm; T4 Er,Lb.
- LDX (5): T3 Ei,Lm; T4 Er,Lx.
- JMP (6): T3 Ei,Lp.
- Conditional jumps emit T3 Ei,Lp only when their flag is 1; otherwise every execute step is idle:
  - JAN (7): am.
  - JAZ (8): az.
  - JIN (9): xm.
  - JIZ (A): xz.
- JMS (B): T3 Ei,Lm; T4 Ep,Wr; T5 Ei,Lp; T6 Cp.
- Opcode C–E: treated as NOP.
- Opcode F, selected by `i[3:0]`:
  - 0 NOP: no execute bits.
  - 1 CLA: T3 Ca.
  - 2 XCH: T3 Ea,Lt; T4 Ex,La; T5 Et,Lx.
  - 3 DEX: T3 Dx.
  - 4 INX: T3 Ix.
  - 5 CMA: T3 Eu,Op=2,La.
  - 6 CMB: T3 Eu,Op=3,Lb.
  - 7 IOR: T3 Eu,Op=4,La.
  - 8 AND: T3 Eu,Op=5,La.
  - 9 NOR: T3 Eu,Op=6,La.
  - A NAN: T3 Eu,Op=7,La.
  - B XOR: T3 Eu,Op=8,La.
  - C BRB: T3 Eb,La.
  - D INP: T3 En,La.
  - E OUT: T3 Ea,Lo.
  - F HLT: T3 no bits; the rising edge leaving T3 sets `hlt`.
- Halt:
  - Once `hlt`=1, `sc` freezes and `con`=0.
  - `hlt` stays set, regardless of `i` or the flags, until reset.

## Timing
- Reset (`clr`=0), asynchronous:
  - `sc`=T1 and `hlt`=0 immediately.
  - `con` is forced to 0 while `clr`=0.
- The first rising edge after `clr` rises keeps `sc` at T1, so T1 lasts one full cycle after release. T2 follows on the next edge.
- `con` decoding is purely combinational. A change of `i` or the flags mid-state takes effect within the same cycle.
- Each instruction takes exactly 6 cycles, except HLT, which stops in T4 with `con`=0.
- Reset asserted mid-instruction or while halted returns the block to T1 with `hlt`=0.

## Test plan
- Reset, then free-run with `i`=0x0F (LDA 15):
  - T1 `con`=0x14000000.
  - T2 `con`=0x22800000.
  - T3 `con`=0x04400000.
  - T4 `con`=0x02200000.
  - T5/T6 `con`=0.
  - T1 again on the 7th cycle.
- ADD then SUB: T5 `con`=0x00202000 for ADD and 0x00202200 for SUB.
- JAN at T3:
  - am=0 → `con`=0.
  - am=1 → `con`=0x08400000.
  - Repeat for JAZ/az, JIN/xm, JIZ/xz.
- `i`=0xFE (OUT): T3 `con`=0x00100040. `i`=0xF2 (XCH): T3/T4/T5 = 0x00100100 / 0x00210000 / 0x00020080.
- `i`=0xFF:
  - `hlt` rises at the edge ending T3, and `con` becomes 0.
  - `sc` stays frozen for more than 10 cycles even when `i` changes.
  - Pulsing `clr` low clears `hlt` and returns `sc` to T1.
- Assert `clr` low mid-T4 of a JMS: `sc`=T1 and `con`=0 without waiting for a clock edge.
